// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-expansion types and constants
//
// Contents:
//   AES128_ROUNDS : AES-128 round count (11 round keys, indices 0..10)
//   state_e       : key_expand_ctrl FSM state type
//   RCON          : round constants indexed by round; entries past 9 are zero
//   rcon_word()   : 32-bit rcon word for a round, constant in bits [31:24]
package aes_pkg;

  localparam int unsigned AES128_ROUNDS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Padded to 16 entries so any 4-bit round index selects a defined value.
  localparam logic [0:15][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 48'h0
  };

  function automatic logic [31:0] rcon_word(input logic [3:0] round);
    return {RCON[round], 24'h000000};
  endfunction

endpackage

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - one AES-128 key-expansion step (combinational)
//
// Ports:
//   key_i  [127:0] : round key N, word w0 in [127:96]
//   rcon_i [31:0]  : round constant word for this step
//   key_o  [127:0] : round key N+1
module key_schedule (
  input  logic [127:0] key_i,
  input  logic [31:0]  rcon_i,
  output logic [127:0] key_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  // SubWord(RotWord(w3)): rotate bytes left by one, then substitute each.
  assign t = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ rcon_i;

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/key_expand_ctrl.sv
// rtl/key_expand_ctrl.sv - AES-128 round-key streaming controller
//
// Accepts a cipher key and streams round keys 0..NUM_ROUNDS one per handshake.
// Optional feature macro KEY_STORE_EN adds a readable store of all round keys.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   key_valid/key_ready   : cipher key handshake, key_in[127:96] is w0
//   abort                 : cancel the expansion in progress (EMIT only)
//   rk_valid/rk_ready     : round key handshake, rk_data / rk_round
//   done                  : one-cycle pulse after the last round key is taken
//   rd_idx, rd_data       : (KEY_STORE_EN) combinational store read, 0 past last
//   store_valid           : (KEY_STORE_EN) store holds a complete schedule
module key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         abort,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         done
`ifdef KEY_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_data,
  output logic         store_valid
`endif
);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] key_q, key_d;
  logic         done_q, done_d;
  logic [127:0] next_key;

  logic key_accept;
  logic rk_fire;
  logic last_round;

  key_schedule u_key_schedule (
    .key_i  (key_q),
    .rcon_i (rcon_word(round_q)),
    .key_o  (next_key)
  );

  assign key_ready  = (state_q == IDLE);
  assign rk_valid   = (state_q == EMIT);
  assign rk_data    = key_q;
  assign rk_round   = round_q;
  assign done       = done_q;

  assign key_accept = key_ready && key_valid;
  // Abort wins over a simultaneous round-key handshake.
  assign rk_fire    = rk_valid && rk_ready && !abort;
  assign last_round = (round_q == 4'(NUM_ROUNDS));

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          key_d   = key_in;
          round_d = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rk_ready) begin
          if (last_round) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

`ifdef KEY_STORE_EN
  logic [127:0] store_q [0:NUM_ROUNDS];
  logic         store_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        store_q[i] <= '0;
      end
      store_valid_q <= 1'b0;
    end else begin
      if (rk_fire) begin
        store_q[round_q] <= key_q;
      end
      if (key_accept || (rk_valid && abort)) begin
        store_valid_q <= 1'b0;
      end else if (rk_fire && last_round) begin
        // Rises together with the done pulse.
        store_valid_q <= 1'b1;
      end
    end
  end

  assign rd_data     = (rd_idx <= 4'(NUM_ROUNDS)) ? store_q[rd_idx] : '0;
  assign store_valid = store_valid_q;
`endif

endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb/tb_key_expand_ctrl.sv - self-checking bench for key_expand_ctrl
module tb_key_expand_ctrl;

  typedef logic [127:0] rk_arr_t [0:10];

  typedef struct {
    logic [127:0] key;
    int           round;
    logic [127:0] rk;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         abort;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         done;
`ifdef KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;
  logic         store_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb [0:255];

  always #5 clk = ~clk;

  key_expand_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_in      (key_in),
    .key_ready   (key_ready),
    .abort       (abort),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_data     (rk_data),
    .rk_round    (rk_round),
    .done        (done)
`ifdef KEY_STORE_EN
    ,
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .store_valid (store_valid)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: GF(2^8) arithmetic, S-box from inverse + affine map,
  // FIPS-197 word-recursive key expansion.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] d = {x, x} << k;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic rk_arr_t model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    rk_arr_t     res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) res[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return res;
  endfunction

  // One complete expansion from IDLE; checks every beat against the model.
  task automatic run_stream(input logic [127:0] key, input bit rand_ready,
                            input bit hold_kv, output rk_arr_t got);
    rk_arr_t      exp;
    logic [127:0] last_data;
    logic [3:0]   last_round;
    bit           stalled = 0;
    int           beats = 0;
    int           cycles = 0;
    exp = model_expand(key);
    check("start_key_ready", key_ready, 1);
    key_valid = 1;
    key_in    = key;
    step();
    if (hold_kv) key_in = ~key;
    else key_valid = 0;
    check("accept_rk_valid", rk_valid, 1);
    check("accept_key_ready", key_ready, 0);
    check("accept_round0", rk_round, 0);
`ifdef KEY_STORE_EN
    check("store_valid_clear_on_accept", store_valid, 0);
`endif
    while (beats < 11 && cycles < 300) begin
      if (stalled) begin
        check("stall_data_stable", rk_data, last_data);
        check("stall_round_stable", rk_round, last_round);
      end
      if (rk_valid !== 1'b1) begin
        check("rk_valid_during_emit", rk_valid, 1);
        break;
      end
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_ready) begin
        check("beat_round", rk_round, beats);
        check("beat_data", rk_data, exp[beats]);
        got[beats] = rk_data;
        beats++;
        stalled = 0;
      end else begin
        stalled    = 1;
        last_data  = rk_data;
        last_round = rk_round;
      end
      step();
      cycles++;
    end
    rk_ready = 0;
    check("all_beats_seen", beats, 11);
    if (!rand_ready) check("continuous_cycles", cycles, 11);
    check("done_pulse", done, 1);
    check("done_key_ready", key_ready, 1);
    check("done_rk_valid", rk_valid, 0);
`ifdef KEY_STORE_EN
    check("store_valid_on_done", store_valid, 1);
`endif
    if (hold_kv) begin
      // key_valid held across the final handshake is taken only once IDLE.
      step();
      check("reaccept_rk_valid", rk_valid, 1);
      check("reaccept_round", rk_round, 0);
      check("reaccept_data", rk_data, ~key);
      check("done_one_cycle", done, 0);
      key_valid = 0;
      abort     = 1;
      step();
      abort = 0;
      check("cleanup_idle", key_ready, 1);
      check("cleanup_no_done", done, 0);
    end else begin
      step();
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic go_to_round(input int n);
    for (int c = 0; c < 40 && !(rk_valid && rk_round == 4'(n)); c++) begin
      rk_ready = 1;
      step();
    end
    rk_ready = 0;
    check("reach_round", rk_round, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    vecs [6];
    rk_arr_t got;
    rk_arr_t exp;
    logic [127:0] k;

    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

    vecs[0] = '{FIPS_KEY, 0, FIPS_KEY};
    vecs[1] = '{FIPS_KEY, 1, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{128'h0, 1, 128'h62636363626363636263636362636363};
    vecs[4] = '{128'h0, 2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    vecs[5] = '{{128{1'b1}}, 1, 128'he8e9e9e917161616e8e9e9e917161616};

    rst = 1; key_valid = 0; key_in = '0; rk_ready = 0; abort = 0;
`ifdef KEY_STORE_EN
    rd_idx = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_key_ready", key_ready, 1);
    check("reset_rk_valid", rk_valid, 0);
    check("reset_done", done, 0);
    check("reset_rk_round", rk_round, 0);
    check("reset_rk_data", rk_data, 0);
`ifdef KEY_STORE_EN
    check("reset_store_valid", store_valid, 0);
`endif
    rst = 0;
    step();
    check("idle_rk_valid", rk_valid, 0);

    // Abort in IDLE does not block a key; held abort then cancels in EMIT.
    key_valid = 1; key_in = FIPS_KEY; abort = 1;
    step();
    check("idle_abort_ignored", rk_valid, 1);
    key_valid = 0;
    step();
    abort = 0;
    check("abort_emit_idle", key_ready, 1);
    check("abort_emit_no_done", done, 0);

    foreach (vecs[i]) begin
      run_stream(vecs[i].key, 0, 0, got);
      check($sformatf("vector%0d_round%0d", i, vecs[i].round), got[vecs[i].round], vecs[i].rk);
    end

`ifdef KEY_STORE_EN
    exp = model_expand(FIPS_KEY);
    run_stream(FIPS_KEY, 0, 0, got);
    check("store_valid_after_done", store_valid, 1);
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i);
      #1;
      check($sformatf("store_rd%0d", i), rd_data, exp[i]);
    end
    rd_idx = 4'd12;
    #1;
    check("store_rd12_zero", rd_data, 0);
    rd_idx = 4'd11;
    #1;
    check("store_rd11_zero", rd_data, 0);
`endif

    run_stream(FIPS_KEY, 1, 0, got);
    run_stream(FIPS_KEY, 0, 1, got);

    for (int r = 0; r < 4; r++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_stream(k, 1, 0, got);
    end

    // Abort together with rk_ready at round 4.
    key_valid = 1; key_in = FIPS_KEY;
    step();
    key_valid = 0;
    go_to_round(4);
    abort = 1; rk_ready = 1;
    step();
    abort = 0; rk_ready = 0;
    check("abort4_rk_valid", rk_valid, 0);
    check("abort4_key_ready", key_ready, 1);
    check("abort4_done", done, 0);
    step();
    check("abort4_done_later", done, 0);
    k = {$urandom, $urandom, $urandom, $urandom};
    run_stream(k, 0, 0, got);

    // Reset at round 7 takes effect without waiting for a clock edge.
    key_valid = 1; key_in = FIPS_KEY;
    step();
    key_valid = 0;
    go_to_round(7);
    rst = 1;
    #1;
    check("rst7_key_ready", key_ready, 1);
    check("rst7_rk_valid", rk_valid, 0);
    check("rst7_done", done, 0);
    check("rst7_rk_round", rk_round, 0);
    check("rst7_rk_data", rk_data, 0);
    step();
    rst = 0;
    step();
    run_stream(FIPS_KEY, 1, 0, got);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expand_ctrl.md
KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10: AES-128 round count; 11 round keys (indices 0..10) are produced.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port key_valid, input, 1: cipher key offered.
REQ-005 SHALL have port key_in, input, 128: cipher key; [127:96] is word w0 (FIPS-197 byte order).
REQ-006 SHALL have port key_ready, output, 1: controller accepts a key.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of the expansion in progress.
REQ-008 SHALL have port rk_valid, output, 1: round key presented.
REQ-009 SHALL have port rk_ready, input, 1: consumer accepts the round key.
REQ-010 SHALL have port rk_data, output, 128: current round key.
REQ-011 SHALL have port rk_round, output, 4: index 0..10 of rk_data.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after round key 10 is accepted.

Function
REQ-013 SHALL implement FSM states IDLE and EMIT.
REQ-014 SHALL hold key_ready=1 in IDLE only, and rk_valid=1 in EMIT only.
REQ-015 SHALL, on key_valid&&key_ready, load key_in into the current-key register, clear the round counter, and enter EMIT, so rk_valid rises the next cycle (1-cycle latency).
REQ-016 SHALL drive rk_data from the current-key register and rk_round from the round counter, both stable while rk_valid&&!rk_ready.
REQ-017 SHALL, on rk_valid&&rk_ready with round<10, replace the current key with the key_schedule result for RCON[round] and increment round; this gives 1 key/cycle under continuous rk_ready.
REQ-018 SHALL apply RCON sequence 01,02,04,08,10,20,40,80,1B,36 in bits [31:24] of the 32-bit rcon word, with bits [23:0]=0.
REQ-019 SHALL, on rk_valid&&rk_ready with round==10, return to IDLE and pulse done in the following cycle, which coincides with the first cycle that key_ready=1.
REQ-020 SHALL ignore key_valid while in EMIT.
REQ-021 SHALL, on abort in EMIT, enter IDLE next cycle with no done pulse; abort takes priority over a simultaneous rk handshake, and abort in IDLE has no effect.
REQ-022 SHALL not accept a new key in the same cycle as the final handshake.

Reset
REQ-023 SHALL, on rst, enter IDLE and set key_ready=1, rk_valid=0, done=0, rk_round=0, rk_data=0, and the current-key register to 0.
REQ-024 SHALL take rst asserted mid-expansion immediately, discarding all progress.

Configuration
REQ-025 SHALL, with KEY_STORE_EN defined, add an 11x128 round-key store written on every rk handshake at index rk_round.
REQ-026 SHALL, with KEY_STORE_EN defined, add ports rd_idx (input, 4), rd_data (output, 128, combinational; 0 for idx>10) and store_valid (output, 1).
REQ-027 SHALL set store_valid on done and clear it on key acceptance, abort or rst; rst also zeros the store.
REQ-028 SHALL, without KEY_STORE_EN, omit the store and these ports, leaving streaming-only behaviour.

Structure
REQ-029 SHALL place the state typedef, the RCON table and the NUM_ROUNDS constant in shared package aes_pkg.
REQ-030 SHALL instantiate the existing key_schedule round function once as its only sub-module.

Verification
REQ-031 SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> round 0 = key, round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, 11 consecutive beats, then done.
REQ-032 SHALL cover: same key with rk_ready toggled randomly -> identical 11-key sequence, rk_data/rk_round stable while stalled.
REQ-033 SHALL cover: abort asserted at round 4 together with rk_ready -> IDLE next cycle, no done, key_ready=1; a subsequent key expands correctly.
REQ-034 SHALL cover: key_valid held high during EMIT -> no reload, sequence unaffected.
REQ-035 SHALL cover: rst asserted at round 7 -> all outputs at reset values immediately.
REQ-036 SHALL cover, with KEY_STORE_EN: after done, rd_idx=10 -> d014f9a8...; rd_idx=12 -> 0; store_valid clears on the next key acceptance.
